// File: rtl/max_reduce_pkg.sv
// -----------------------------------------------------------------------------
// max_reduce_pkg
//   Shared types and default constants for the streaming max-reduction block.
//   Contents:
//     state_e      controller states (IDLE, ACCUM, DONE)
//     DEF_WIDTH    default operand width
//     DEF_MAX_LEN  default maximum beats per packet
// -----------------------------------------------------------------------------
package max_reduce_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_MAX_LEN = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage : max_reduce_pkg

// File: rtl/max_reduce_seq_max_sel.sv
// -----------------------------------------------------------------------------
// max_sel
//   Combinational unsigned compare/select unit.
//   Ports:
//     a   in   WIDTH  candidate operand (new beat)
//     b   in   WIDTH  incumbent operand (running maximum)
//     gt  out  1      a > b (strict, unsigned)
//     y   out  WIDTH  larger of a and b; b wins on a tie
// -----------------------------------------------------------------------------
module max_sel #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt,
  output logic [WIDTH-1:0] y
);

  // Strict compare so that equal values keep the incumbent (earlier index).
  assign gt = (a > b);
  assign y  = gt ? a : b;

endmodule : max_sel

// File: rtl/max_reduce_seq.sv
// -----------------------------------------------------------------------------
// max_reduce_seq
//   Streaming max-reduction controller. Accepts a packet of unsigned words on a
//   valid/ready stream, reuses a single max_sel unit once per beat, and reports
//   the packet maximum, the index of its first occurrence and the beat count.
//   Ports:
//     clk        in   1        rising-edge clock
//     rst_n      in   1        asynchronous active-low reset
//     soft_clr   in   1        synchronous abort, returns to IDLE
//     in_valid   in   1        input beat valid
//     in_ready   out  1        block accepts a beat (IDLE / ACCUM only)
//     in_data    in   WIDTH    operand
//     in_last    in   1        last beat of the packet
//     out_valid  out  1        result valid (DONE)
//     out_ready  in   1        result consumer ready
//     out_max    out  WIDTH    packet maximum
//     out_idx    out  IDX_W    0-based index of first beat equal to out_max
//     out_cnt    out  IDX_W+1  beats in the packet
//     out_ovf    out  1        packet was truncated at MAX_LEN
// -----------------------------------------------------------------------------
module max_reduce_seq
  import max_reduce_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int IDX_W   = $clog2(MAX_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             soft_clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [IDX_W-1:0] out_idx,
  output logic [IDX_W:0]   out_cnt,
  output logic             out_ovf
);

  localparam logic [IDX_W:0] MAX_CNT = (IDX_W+1)'(MAX_LEN);
  localparam logic [IDX_W:0] ONE_CNT = (IDX_W+1)'(1);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_e           state_q,     state_d;
  logic             rdy_q,       rdy_d;
  logic [WIDTH-1:0] acc_q,       acc_d;
  logic [IDX_W-1:0] idx_q,       idx_d;
  logic [IDX_W:0]   cnt_q,       cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_max_q,   out_max_d;
  logic [IDX_W-1:0] out_idx_q,   out_idx_d;
  logic [IDX_W:0]   out_cnt_q,   out_cnt_d;
  logic             out_ovf_q,   out_ovf_d;

  logic             beat_fire;
  logic [IDX_W:0]   cnt_inc;
  logic [IDX_W-1:0] beat_idx;
  logic             sel_gt;
  logic [WIDTH-1:0] sel_y;

  // ---------------------------------------------------------------------------
  // Shared compare/select unit: new beat against the running maximum.
  // ---------------------------------------------------------------------------
  max_sel #(
    .WIDTH (WIDTH)
  ) u_max_sel (
    .a  (in_data),
    .b  (acc_q),
    .gt (sel_gt),
    .y  (sel_y)
  );

  assign beat_fire = in_valid && rdy_q;
  assign cnt_inc   = cnt_q + 1'b1;
  // In ACCUM cnt_q never exceeds MAX_LEN-1, so it fits the index field and
  // equals the 0-based position of the beat being accepted.
  assign beat_idx  = cnt_q[IDX_W-1:0];

  // ---------------------------------------------------------------------------
  // Next-state / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_max_d   = out_max_q;
    out_idx_d   = out_idx_q;
    out_cnt_d   = out_cnt_q;
    out_ovf_d   = out_ovf_q;

    unique case (state_q)
      IDLE: begin
        if (beat_fire) begin
          acc_d = in_data;
          idx_d = '0;
          cnt_d = ONE_CNT;
          if (in_last) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            out_max_d   = in_data;
            out_idx_d   = '0;
            out_cnt_d   = ONE_CNT;
            out_ovf_d   = 1'b0;
          end else begin
            state_d = ACCUM;
          end
        end
      end

      ACCUM: begin
        if (beat_fire) begin
          cnt_d = cnt_inc;
          if (sel_gt) begin
            acc_d = in_data;
            idx_d = beat_idx;
          end
          if (in_last || (cnt_inc == MAX_CNT)) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            out_max_d   = sel_y;
            out_idx_d   = sel_gt ? beat_idx : idx_q;
            out_cnt_d   = cnt_inc;
            // Reaching DONE without in_last can only mean the length cap hit;
            // the sender's remaining beats will open a fresh packet.
            out_ovf_d   = !in_last;
          end
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    // Abort wins over every handshake and wipes the result registers as well.
    if (soft_clr) begin
      state_d     = IDLE;
      acc_d       = '0;
      idx_d       = '0;
      cnt_d       = '0;
      out_valid_d = 1'b0;
      out_max_d   = '0;
      out_idx_d   = '0;
      out_cnt_d   = '0;
      out_ovf_d   = 1'b0;
    end

    // Ready is registered so it stays low while in reset and for the first
    // edge after release; afterwards it tracks "not in DONE".
    rdy_d = (state_d != DONE);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rdy_q       <= 1'b0;
      acc_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_max_q   <= '0;
      out_idx_q   <= '0;
      out_cnt_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= rdy_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_max_q   <= out_max_d;
      out_idx_q   <= out_idx_d;
      out_cnt_q   <= out_cnt_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = out_valid_q;
  assign out_max   = out_max_q;
  assign out_idx   = out_idx_q;
  assign out_cnt   = out_cnt_q;
  assign out_ovf   = out_ovf_q;

endmodule : max_reduce_seq

// File: tb/tb_max_reduce_seq.sv
// -----------------------------------------------------------------------------
// tb_max_reduce_seq
//   Directed bench for max_reduce_seq built with MAX_LEN=4 so the length cap
//   is reachable with short packets.
// -----------------------------------------------------------------------------
module tb_max_reduce_seq;

  localparam int WIDTH   = 32;
  localparam int MAX_LEN = 4;
  localparam int IDX_W   = $clog2(MAX_LEN);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             soft_clr;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_max;
  logic [IDX_W-1:0] out_idx;
  logic [IDX_W:0]   out_cnt;
  logic             out_ovf;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  max_reduce_seq #(
    .WIDTH   (WIDTH),
    .MAX_LEN (MAX_LEN),
    .IDX_W   (IDX_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .soft_clr  (soft_clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_max   (out_max),
    .out_idx   (out_idx),
    .out_cnt   (out_cnt),
    .out_ovf   (out_ovf)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one beat and hold it until accepted (bounded wait).
  // Returns at posedge+1 of the accepting edge.
  task automatic send(input logic [WIDTH-1:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("send_ready_%0h", d), 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    $display("[TB] beat data=0x%08h last=%0b", d, l);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called right after the final beat: checks 1-cycle latency, the result,
  // then completes the output handshake and checks the return to IDLE.
  task automatic expect_res(input string tag, input logic [WIDTH-1:0] mx,
                            input int ix, input int cn, input logic ov);
    chk({tag, ".valid"},  64'(out_valid), 64'd1);
    chk({tag, ".max"},    64'(out_max),   64'(mx));
    chk({tag, ".idx"},    64'(out_idx),   64'(ix));
    chk({tag, ".cnt"},    64'(out_cnt),   64'(cn));
    chk({tag, ".ovf"},    64'(out_ovf),   64'(ov));
    chk({tag, ".rdy_lo"}, 64'(in_ready),  64'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    $display("[TB] result %s max=0x%08h idx=%0d cnt=%0d ovf=%0b", tag, out_max, out_idx, out_cnt, out_ovf);
    chk({tag, ".valid_lo"}, 64'(out_valid), 64'd0);
    chk({tag, ".rdy_hi"},   64'(in_ready),  64'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    soft_clr  = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.in_ready",  64'(in_ready),  64'd0);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.out_max",   64'(out_max),   64'd0);
    chk("rst.out_idx",   64'(out_idx),   64'd0);
    chk("rst.out_cnt",   64'(out_cnt),   64'd0);
    chk("rst.out_ovf",   64'(out_ovf),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1. Single-beat packet
    send(32'h0000_0005, 1'b1);
    expect_res("t1", 32'h0000_0005, 0, 1, 1'b0);

    // 2. Tie keeps the first index; last on the 4th beat is not an overflow
    send(32'h0000_0003, 1'b0);
    send(32'hFFFF_FFFF, 1'b0);
    send(32'h0000_0007, 1'b0);
    send(32'hFFFF_FFFF, 1'b1);
    expect_res("t2", 32'hFFFF_FFFF, 1, 4, 1'b0);

    // 3. Unsigned compare
    send(32'h8000_0000, 1'b0);
    send(32'h7FFF_FFFF, 1'b1);
    expect_res("t3", 32'h8000_0000, 0, 2, 1'b0);

    // 4. Truncation at MAX_LEN, remainder forms a new packet
    send(32'd1, 1'b0);
    send(32'd2, 1'b0);
    send(32'd3, 1'b0);
    send(32'd4, 1'b0);
    expect_res("t4a", 32'd4, 3, 4, 1'b1);
    send(32'd5, 1'b0);
    send(32'd6, 1'b1);
    expect_res("t4b", 32'd6, 1, 2, 1'b0);

    // 5. Output back-pressure for 10 cycles
    send(32'd10, 1'b0);
    send(32'd20, 1'b1);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t5.hold_valid_%0d", i), 64'(out_valid), 64'd1);
      chk($sformatf("t5.hold_max_%0d", i),   64'(out_max),   64'd20);
      chk($sformatf("t5.hold_rdy_%0d", i),   64'(in_ready),  64'd0);
      @(posedge clk);
      #1;
    end
    expect_res("t5", 32'd20, 1, 2, 1'b0);

    // 6. soft_clr mid-packet
    send(32'd11, 1'b0);
    send(32'd12, 1'b0);
    soft_clr = 1'b1;
    @(posedge clk);
    #1;
    soft_clr = 1'b0;
    $display("[TB] soft_clr applied");
    chk("t6.clr_valid", 64'(out_valid), 64'd0);
    chk("t6.clr_max",   64'(out_max),   64'd0);
    chk("t6.clr_cnt",   64'(out_cnt),   64'd0);
    chk("t6.clr_rdy",   64'(in_ready),  64'd1);
    // Counter restarts cleanly after the abort
    send(32'd13, 1'b1);
    expect_res("t6a", 32'd13, 0, 1, 1'b0);

    // Asynchronous reset mid-ACCUM
    send(32'd14, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    $display("[TB] async reset asserted mid-packet");
    chk("t6.rst_valid", 64'(out_valid), 64'd0);
    chk("t6.rst_rdy",   64'(in_ready),  64'd0);
    chk("t6.rst_max",   64'(out_max),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(32'd9, 1'b0);
    send(32'd2, 1'b1);
    expect_res("t6b", 32'd9, 0, 2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_max_reduce_seq
